// File: rtl/sicaklik_okuyucu.sv
// Temperature sensor reader: periodically clocks a 16-bit frame out of a SPI-like sensor
// and publishes the floor average of the last four valid readings.
module sicaklik_okuyucu #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sensor_miso,
    output logic       sensor_sclk,
    output logic       sensor_cs_n,
    output logic [7:0] sicaklik,
    output logic       sicaklik_valid,
    output logic       hata
);

    localparam int              PW          = $clog2(SAMPLE_PERIOD);
    localparam logic [PW-1:0]   PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [7:0]      DIV_LAST    = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        PROCESS
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] periodCnt_q, periodCnt_d;
    logic [7:0]    divCnt_q, divCnt_d;
    logic [4:0]    halfCnt_q, halfCnt_d;
    logic [15:0]   frame_q, frame_d;
    logic          sclk_q, sclk_d;
    logic          csN_q, csN_d;
    logic [7:0]    hist_q [4];
    logic [7:0]    hist_d [4];
    logic [2:0]    count_q, count_d;
    logic [7:0]    sicaklik_q, sicaklik_d;
    logic          valid_q, valid_d;
    logic          hata_q, hata_d;

    logic          trigger;
    logic          divDone;
    logic [9:0]    sum;

    // The period counter is held at its reload value while disabled so a rising
    // enable always waits a full SAMPLE_PERIOD before the first trigger.
    always_comb begin
        periodCnt_d = periodCnt_q;
        if (!enable || periodCnt_q == '0) begin
            periodCnt_d = PERIOD_LAST;
        end else begin
            periodCnt_d = periodCnt_q - PW'(1);
        end
    end

    assign trigger = enable && (periodCnt_q == '0);
    assign divDone = (divCnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        halfCnt_d = halfCnt_q;
        frame_d   = frame_q;
        sclk_d    = sclk_q;
        case (state_q)
            IDLE: begin
                divCnt_d  = '0;
                halfCnt_d = '0;
                sclk_d    = 1'b0;
                if (trigger) begin
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (divDone) begin
                    divCnt_d = '0;
                    state_d  = SHIFT;
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            SHIFT: begin
                // Even half-periods are low, odd are high; sample as sclk rises.
                if (divDone) begin
                    divCnt_d = '0;
                    if (halfCnt_q == 5'd31) begin
                        sclk_d  = 1'b0;
                        state_d = CS_HOLD;
                    end else begin
                        halfCnt_d = halfCnt_q + 5'd1;
                        sclk_d    = ~halfCnt_q[0];
                        if (!halfCnt_q[0]) begin
                            frame_d = {frame_q[14:0], sensor_miso};
                        end
                    end
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            CS_HOLD: begin
                if (divDone) begin
                    divCnt_d = '0;
                    state_d  = PROCESS;
                end else begin
                    divCnt_d = divCnt_q + 8'd1;
                end
            end
            PROCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        csN_d = !(state_d inside {CS_SETUP, SHIFT, CS_HOLD});
    end

    assign sum = {{2{frame_q[15]}},   frame_q[15:8]}
               + {{2{hist_q[0][7]}}, hist_q[0]}
               + {{2{hist_q[1][7]}}, hist_q[1]}
               + {{2{hist_q[2][7]}}, hist_q[2]};

    // Results are registered at the end of PROCESS so pulses appear the cycle after.
    always_comb begin
        hist_d     = hist_q;
        count_d    = count_q;
        sicaklik_d = sicaklik_q;
        valid_d    = 1'b0;
        hata_d     = 1'b0;
        if (state_q == PROCESS) begin
            if (frame_q[0]) begin
                hata_d = 1'b1;
            end else begin
                hist_d[0] = frame_q[15:8];
                hist_d[1] = hist_q[0];
                hist_d[2] = hist_q[1];
                hist_d[3] = hist_q[2];
                if (count_q != 3'd4) begin
                    count_d = count_q + 3'd1;
                end
                if (count_d == 3'd4) begin
                    sicaklik_d = sum[9:2];
                    valid_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            periodCnt_q <= PERIOD_LAST;
            divCnt_q    <= '0;
            halfCnt_q   <= '0;
            frame_q     <= '0;
            sclk_q      <= 1'b0;
            csN_q       <= 1'b1;
            hist_q      <= '{default: '0};
            count_q     <= '0;
            sicaklik_q  <= '0;
            valid_q     <= 1'b0;
            hata_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            periodCnt_q <= periodCnt_d;
            divCnt_q    <= divCnt_d;
            halfCnt_q   <= halfCnt_d;
            frame_q     <= frame_d;
            sclk_q      <= sclk_d;
            csN_q       <= csN_d;
            hist_q      <= hist_d;
            count_q     <= count_d;
            sicaklik_q  <= sicaklik_d;
            valid_q     <= valid_d;
            hata_q      <= hata_d;
        end
    end

    assign sensor_sclk    = sclk_q;
    assign sensor_cs_n    = csN_q;
    assign sicaklik       = sicaklik_q;
    assign sicaklik_valid = valid_q;
    assign hata           = hata_q;

endmodule

// File: tb/tb_sicaklik_okuyucu.sv
// Bench for sicaklik_okuyucu: a bit-serial sensor model feeds frames while a queue-based
// averaging model predicts every valid/hata pulse and temperature.
module tb_sicaklik_okuyucu;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       sensorMiso;
    logic       sclk;
    logic       csN;
    logic [7:0] sicaklik;
    logic       valid;
    logic       hata;

    logic       fastEnable;
    logic       fastSclk;
    logic       fastCsN;
    logic [7:0] fastSicaklik;
    logic       fastValid;
    logic       fastHata;

    int checks = 0;
    int errors = 0;

    logic [15:0] sensorWord = 16'h0000;
    int          bitIdx = 0;
    int          hist[$];
    int          expSicaklik = 0;

    sicaklik_okuyucu #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sensor_miso(sensorMiso),
        .sensor_sclk(sclk), .sensor_cs_n(csN), .sicaklik(sicaklik),
        .sicaklik_valid(valid), .hata(hata)
    );

    // Deliberately shorter period than a frame, so a mid-frame trigger must be dropped.
    sicaklik_okuyucu #(.CLK_DIV(2), .SAMPLE_PERIOD(50)) dutFast (
        .clk(clk), .reset(reset), .enable(fastEnable), .sensor_miso(1'b0),
        .sensor_sclk(fastSclk), .sensor_cs_n(fastCsN), .sicaklik(fastSicaklik),
        .sicaklik_valid(fastValid), .hata(fastHata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sensor presents the MSB while cs_n is low and advances one bit per sclk fall.
    always @(negedge sclk or posedge csN) begin
        if (csN) bitIdx = 0;
        else     bitIdx = bitIdx + 1;
    end
    assign sensorMiso = (bitIdx < 16) ? sensorWord[4'(15 - bitIdx)] : 1'b0;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int floorDiv4(input int s);
        if (s >= 0) return s / 4;
        return -((-s + 3) / 4);
    endfunction

    // Runs one frame end to end and checks framing, pulses and the averaged result.
    task automatic applyStimulus(input logic [15:0] word, input string tag,
                                 input bit dropEnable, input int expWait);
        int n;
        int lowCycles;
        int rises;
        int sum;
        logic prevSclk;
        bit expValid;
        bit expHata;
        sensorWord = word;
        n = 0;
        while (csN !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (csN !== 1'b0) begin
            checkOutput({tag, " cs_n fall timeout"}, int'(csN), 0);
            return;
        end
        if (expWait >= 0) checkOutput({tag, " trigger delay"}, n, expWait);
        if (dropEnable) enable = 1'b0;
        lowCycles = 0;
        rises = 0;
        prevSclk = sclk;
        while (csN === 1'b0 && lowCycles < 1000) begin
            lowCycles++;
            @(negedge clk);
            if (sclk && !prevSclk) rises++;
            prevSclk = sclk;
        end
        checkOutput({tag, " cs_n low cycles"}, lowCycles, 68);
        checkOutput({tag, " sclk pulses"}, rises, 16);
        checkOutput({tag, " valid during PROCESS"}, int'(valid), 0);

        expValid = 1'b0;
        expHata  = 1'b0;
        if (word[0]) begin
            expHata = 1'b1;
        end else begin
            hist.push_front(int'($signed(word[15:8])));
            if (hist.size() > 4) void'(hist.pop_back());
            if (hist.size() == 4) begin
                sum = 0;
                foreach (hist[i]) sum += hist[i];
                expSicaklik = floorDiv4(sum);
                expValid = 1'b1;
            end
        end

        @(negedge clk);
        checkOutput({tag, " valid"}, int'(valid), int'(expValid));
        checkOutput({tag, " hata"}, int'(hata), int'(expHata));
        checkOutput({tag, " sicaklik"}, int'($signed(sicaklik)), expSicaklik);
        @(negedge clk);
        checkOutput({tag, " valid one cycle"}, int'(valid), 0);
        checkOutput({tag, " hata one cycle"}, int'(hata), 0);
    endtask

    task automatic pulseReset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
        hist.delete();
        expSicaklik = 0;
    endtask

    function automatic logic [15:0] randomFrame(input bit allowNotReady);
        logic [15:0] w;
        w = 16'($urandom);
        w[0] = allowNotReady && ($urandom_range(0, 4) == 0);
        return w;
    endfunction

    initial begin
        int n;
        int activity;
        int rises;
        logic prevSclk;
        logic prevCs;

        reset = 1'b0;
        enable = 1'b0;
        fastEnable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset cs_n", int'(csN), 1);
        checkOutput("reset sclk", int'(sclk), 0);
        checkOutput("reset sicaklik", int'(sicaklik), 0);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset hata", int'(hata), 0);
        reset = 1'b1;

        activity = 0;
        repeat (200) begin
            @(negedge clk);
            if (sclk || !csN) activity++;
        end
        checkOutput("idle while disabled", activity, 0);

        enable = 1'b1;
        applyStimulus(16'h1900, "f1", 1'b0, 100);
        applyStimulus(16'h1900, "f2", 1'b0, -1);
        applyStimulus(16'h1900, "f3", 1'b0, -1);
        applyStimulus(16'h1900, "f4", 1'b0, -1);
        applyStimulus(16'h1901, "notready", 1'b0, -1);
        applyStimulus(16'h1900, "after notready", 1'b0, -1);
        applyStimulus(16'h2300, "f35", 1'b0, -1);

        pulseReset(2);
        applyStimulus(16'hFB00, "neg1", 1'b0, 100);
        applyStimulus(16'hFB00, "neg2", 1'b0, -1);
        applyStimulus(16'hFB00, "neg3", 1'b0, -1);
        applyStimulus(16'hFA00, "neg4", 1'b0, -1);

        sensorWord = randomFrame(1'b0);
        n = 0;
        while (csN !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        rises = 0;
        prevSclk = sclk;
        n = 0;
        while (rises < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclk && !prevSclk) rises++;
            prevSclk = sclk;
        end
        checkOutput("abort reached 8th sclk", rises, 8);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort cs_n", int'(csN), 1);
        checkOutput("abort sclk", int'(sclk), 0);
        checkOutput("abort sicaklik", int'(sicaklik), 0);
        reset = 1'b1;
        hist.delete();
        expSicaklik = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(randomFrame(1'b0), $sformatf("post-abort %0d", i), 1'b0, -1);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(randomFrame(1'b1), $sformatf("rand %0d", i), 1'b0, -1);
        end

        applyStimulus(randomFrame(1'b0), "enable drop", 1'b1, -1);
        activity = 0;
        repeat (300) begin
            @(negedge clk);
            if (sclk || !csN) activity++;
        end
        checkOutput("no frames after disable", activity, 0);

        @(negedge clk);
        fastEnable = 1'b1;
        n = 0;
        while (fastCsN !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fast first trigger", n, 50);
        for (int f = 0; f < 2; f++) begin
            n = 0;
            while (fastCsN === 1'b0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("fast frame %0d cs_n low", f), n, 68);
            prevCs = fastCsN;
            while (!(fastCsN === 1'b0 && prevCs === 1'b1) && n < 400) begin
                prevCs = fastCsN;
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("fast frame %0d start spacing", f), n, 100);
        end
        fastEnable = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sicaklik_okuyucu.md
SICAKLIK_OKUYUCU -- requirements
Module: sicaklik_okuyucu

Interface
REQ-001 Parameter CLK_DIV, default 4, gives the number of clk cycles per sensor_sclk half-period; legal range is 1..255.
REQ-002 Parameter SAMPLE_PERIOD, default 1000, gives the number of clk cycles between conversion triggers; it SHALL be at least 34*CLK_DIV+2.
REQ-003 Port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: while high, periodic conversions run.
REQ-006 Port sensor_miso, input, 1 bit: serial data from the temperature sensor.
REQ-007 Port sensor_sclk, output, 1 bit: serial clock to the sensor, idle low.
REQ-008 Port sensor_cs_n, output, 1 bit: sensor chip select, active low.
REQ-009 Port sicaklik, output, 8 bits: signed two's-complement averaged temperature in °C, feeding the air-conditioner controller.
REQ-010 Port sicaklik_valid, output, 1 bit: one-cycle pulse marking a new sicaklik value.
REQ-011 Port hata, output, 1 bit: one-cycle pulse marking a discarded frame.

Function
REQ-012 The period counter SHALL run only while enable=1, reload to SAMPLE_PERIOD-1, and issue a trigger when it reaches 0.
REQ-013 A trigger arriving while a frame is in progress SHALL be dropped.
REQ-014 The FSM SHALL have the states IDLE, CS_SETUP, SHIFT, CS_HOLD and PROCESS.
REQ-015 IDLE -> CS_SETUP on a trigger; sensor_cs_n goes low on the same edge.
REQ-016 CS_SETUP SHALL last CLK_DIV cycles with sensor_sclk low, then go to SHIFT.
REQ-017 SHIFT SHALL generate 16 sensor_sclk periods of 2*CLK_DIV cycles each, low half first.
REQ-018 On each sensor_sclk rising edge, SHIFT SHALL sample sensor_miso MSB first into a 16-bit frame register.
REQ-019 After the 16th high half ends, sclk SHALL return low and the FSM SHALL go to CS_HOLD.
REQ-020 CS_HOLD SHALL last CLK_DIV cycles with sensor_cs_n low, then raise sensor_cs_n and go to PROCESS.
REQ-021 PROCESS SHALL last one cycle, then return to IDLE.
REQ-022 Frame format: bits [15:8] are the signed integer temperature, bits [7:1] are ignored, and bit [0] is not-ready.
REQ-023 If bit [0]=1, PROCESS SHALL discard the frame and assert hata for exactly one cycle, starting the cycle after PROCESS; history, count and sicaklik SHALL be unchanged, with no valid pulse.
REQ-024 If bit [0]=0, PROCESS SHALL shift bits [15:8] into a 4-entry sample history, newest first, oldest dropped.
REQ-025 For each accepted sample, a saturating valid-sample count (0..4) SHALL increment.
REQ-026 Average = (sum of the 4 entries, sign-extended to 10 bits) arithmetic-shifted right by 2, i.e. floor toward minus infinity; no overflow is possible.
REQ-027 When the count equals 4 after the update, sicaklik SHALL load the average and sicaklik_valid SHALL pulse for one cycle, starting the cycle after PROCESS.
REQ-028 When the count is below 4 after the update, there SHALL be no valid pulse and sicaklik SHALL hold.
REQ-029 sicaklik SHALL hold its last value between valid pulses.
REQ-030 If enable falls mid-frame, the current frame SHALL complete, including PROCESS, and no further triggers SHALL occur.
REQ-031 When enable rises, the period counter SHALL restart from SAMPLE_PERIOD-1, so the first trigger comes SAMPLE_PERIOD cycles later.
REQ-032 Total frame length SHALL be 34*CLK_DIV cycles with cs_n low, plus 1 PROCESS cycle.

Reset
REQ-033 With reset=0 at a rising clk edge, the outputs SHALL be sensor_cs_n=1, sensor_sclk=0, sicaklik=8'h00, sicaklik_valid=0, hata=0.
REQ-034 The same reset edge SHALL set FSM=IDLE, clear the history and count, and reload the period counter to SAMPLE_PERIOD-1.
REQ-035 Reset asserted mid-frame SHALL abort the frame at that edge with no partial-frame effect; after release, 4 new valid frames are required before a valid pulse.

Verification (CLK_DIV=2, SAMPLE_PERIOD=100)
REQ-036 Hold reset=0 for 3 cycles -> cs_n=1, sclk=0, sicaklik=0, valid=0, hata=0; no sclk activity with enable=0.
REQ-037 With enable=1, the sensor model returns 0x1900 four times -> each frame has cs_n low for 68 cycles and 16 sclk pulses; frames 1-3 give no valid; frame 4 gives valid with sicaklik=25 (0x19).
REQ-038 Then frame 0x2300 (35) -> valid with sicaklik=27, since 110>>2.
REQ-039 After reset, frames 0xFB00, 0xFB00, 0xFB00, 0xFA00 (-5,-5,-5,-6) -> valid with sicaklik=-6 (0xFA), since -21>>>2=-6.
REQ-040 With history full at 25, frame 0x1901 -> hata pulses once, no valid, and sicaklik stays 25; the next frame 0x1900 gives valid with sicaklik=25.
REQ-041 Reset pulsed at the 8th sclk rising edge -> cs_n=1 and sclk=0 at the next edge; after release, frames 1-3 give no valid, and a trigger during a frame (SAMPLE_PERIOD forced to 50) is dropped with no overlapping cs_n.
